// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Watches a multiplexed 8-digit 7-segment bus and rebuilds the two 16-bit
// values it displays. Digits 7..4 map to val_1_o and digits 3..0 to val_2_o.
// Build option: define SEG_SYNC_EN to pass an_i/seg_i through 2-FF
// synchronizers. This is for pins driven from an asynchronous source and
// adds 2 cycles of latency.
module seg_scan_decoder #(
  parameter int DIGITS        = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT       = 1048576
) (
  input  logic        clk_100MHz_i,
  input  logic        rst,
  input  logic [7:0]  an_i,
  input  logic [7:0]  seg_i,
  output logic [15:0] val_1_o,
  output logic [15:0] val_2_o,
  output logic [7:0]  dp_o,
  output logic        valid_o,
  output logic        err_o,
  output logic        timeout_o
);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_HIT  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_HIT  = TMR_W'(TIMEOUT - 1);
  localparam logic [DIGITS-1:0] ALL_SEEN = '1;

  typedef enum logic {HUNT, ACQ} state_t;

  logic [7:0] an_in;
  logic [7:0] seg_in;

`ifdef SEG_SYNC_EN
  logic [7:0] an_s1_reg, an_s2_reg, seg_s1_reg, seg_s2_reg;

  // Two-stage synchronizer. It resets to the blank / all-off bus state.
  always_ff @(posedge clk_100MHz_i) begin
    if (rst) begin
      an_s1_reg  <= 8'hFF;
      an_s2_reg  <= 8'hFF;
      seg_s1_reg <= 8'hFF;
      seg_s2_reg <= 8'hFF;
    end else begin
      an_s1_reg  <= an_i;
      an_s2_reg  <= an_s1_reg;
      seg_s1_reg <= seg_i;
      seg_s2_reg <= seg_s1_reg;
    end
  end

  assign an_in  = an_s2_reg;
  assign seg_in = seg_s2_reg;
`else
  assign an_in  = an_i;
  assign seg_in = seg_i;
`endif

  logic [7:0]       an_prev_reg;
  logic [7:0]       seg_prev_reg;
  logic [CNT_W-1:0] stab_cnt_reg;

  // Track how long the anode code has been stable.
  // The counter resets to saturated, so reset itself never causes a sample.
  always_ff @(posedge clk_100MHz_i) begin
    if (rst) begin
      an_prev_reg  <= 8'hFF;
      seg_prev_reg <= 8'hFF;
      stab_cnt_reg <= CNT_MAX;
    end else begin
      an_prev_reg  <= an_in;
      seg_prev_reg <= seg_in;
      if (an_in != an_prev_reg) begin
        stab_cnt_reg <= '0;
      end else if (stab_cnt_reg != CNT_MAX) begin
        stab_cnt_reg <= stab_cnt_reg + CNT_W'(1);
      end
    end
  end

  logic             sample;
  logic [7:0]       an_act;
  logic             an_blank;
  logic             an_onehot;
  logic [6:0]       seg_act;
  logic [3:0]       nib_dec;
  logic             seg_legal;
  logic             dig_stb;
  logic             bad_stb;
  logic [DIGITS-1:0] seen_reg;
  logic [DIGITS-1:0] seen_next;
  logic             frame_done;
  state_t           state_reg;

  // The counter passes through SETTLE_CYCLES-1 exactly once per stable run.
  assign sample    = (stab_cnt_reg == CNT_HIT);
  assign an_act    = ~an_prev_reg;
  assign an_blank  = (an_prev_reg == 8'hFF);
  assign an_onehot = !an_blank && ((an_act & (an_act - 8'd1)) == 8'd0);
  assign seg_act   = ~seg_prev_reg[6:0];
  assign dig_stb   = sample && an_onehot;
  assign bad_stb   = sample && ((!an_onehot && !an_blank) || (an_onehot && !seg_legal));
  assign seen_next = seen_reg | an_act;
  assign frame_done = dig_stb && (state_reg == ACQ) && (seen_next == ALL_SEEN);

  // Map a segment pattern back to a hex nibble.
  // Unknown patterns decode as 0 and are flagged.
  always_comb begin
    nib_dec   = 4'h0;
    seg_legal = 1'b1;
    case (seg_act)
      7'h3F: nib_dec = 4'h0;
      7'h06: nib_dec = 4'h1;
      7'h5B: nib_dec = 4'h2;
      7'h4F: nib_dec = 4'h3;
      7'h66: nib_dec = 4'h4;
      7'h6D: nib_dec = 4'h5;
      7'h7D: nib_dec = 4'h6;
      7'h07: nib_dec = 4'h7;
      7'h7F: nib_dec = 4'h8;
      7'h6F: nib_dec = 4'h9;
      7'h77: nib_dec = 4'hA;
      7'h7C: nib_dec = 4'hB;
      7'h39: nib_dec = 4'hC;
      7'h5E: nib_dec = 4'hD;
      7'h79: nib_dec = 4'hE;
      7'h71: nib_dec = 4'hF;
      default: seg_legal = 1'b0;
    endcase
  end

  logic [4*DIGITS-1:0] shadow_nibs;
  logic [DIGITS-1:0]   shadow_dps;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_shadow
      logic [3:0] nib_reg;
      logic       dp_reg;
      logic       wr_en;

      // While hunting, only digit 0 is accepted; it starts a frame.
      assign wr_en = dig_stb && an_act[gi] && ((state_reg == ACQ) || (gi == 0));

      // Store the most recent decode of digit gi.
      always_ff @(posedge clk_100MHz_i) begin
        if (rst) begin
          nib_reg <= 4'h0;
          dp_reg  <= 1'b0;
        end else if (wr_en) begin
          nib_reg <= nib_dec;
          dp_reg  <= ~seg_prev_reg[7];
        end
      end

      assign shadow_nibs[gi*4 +: 4] = nib_reg;
      assign shadow_dps[gi]         = dp_reg;
    end
  endgenerate

  logic             pending_reg;
  logic [TMR_W-1:0] timer_reg;
  logic [15:0]      val_1_reg;
  logic [15:0]      val_2_reg;
  logic [7:0]       dp_reg;
  logic             valid_reg;
  logic             err_reg;
  logic             timeout_reg;

  // Frame assembly: hunt for digit 0, collect all digits, publish the frame
  // one cycle later, and give up if a frame takes too long.
  always_ff @(posedge clk_100MHz_i) begin
    if (rst) begin
      state_reg   <= HUNT;
      seen_reg    <= '0;
      pending_reg <= 1'b0;
      timer_reg   <= '0;
      val_1_reg   <= '0;
      val_2_reg   <= '0;
      dp_reg      <= '0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (bad_stb) begin
        err_reg <= 1'b1;
      end
      case (state_reg)
        HUNT: begin
          pending_reg <= 1'b0;
          timer_reg   <= '0;
          if (dig_stb && an_act[0]) begin
            seen_reg  <= DIGITS'(1);
            state_reg <= ACQ;
          end
        end
        ACQ: begin
          if (pending_reg) begin
            // Completion takes priority over any timer expiry.
            val_1_reg   <= shadow_nibs[31:16];
            val_2_reg   <= shadow_nibs[15:0];
            dp_reg      <= shadow_dps;
            valid_reg   <= 1'b1;
            pending_reg <= 1'b0;
            timer_reg   <= '0;
            seen_reg    <= dig_stb ? an_act : '0;
          end else if ((timer_reg == TMR_HIT) && !frame_done) begin
            timeout_reg <= 1'b1;
            seen_reg    <= '0;
            state_reg   <= HUNT;
          end else begin
            if (timer_reg != TMR_HIT) begin
              timer_reg <= timer_reg + TMR_W'(1);
            end
            if (dig_stb) begin
              seen_reg <= seen_next;
            end
            if (frame_done) begin
              pending_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= HUNT;
      endcase
    end
  end

  assign val_1_o   = val_1_reg;
  assign val_2_o   = val_2_reg;
  assign dp_o      = dp_reg;
  assign valid_o   = valid_reg;
  assign err_o     = err_reg;
  assign timeout_o = timeout_reg;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
// Drives whole display scans as a list of (anode, segments, hold) steps.
// A step-level model predicts the frames, flags and publish cycle.
// If SEG_SYNC_EN is defined, the expected latency grows by 2 cycles.
module tb_seg_scan_decoder;
  localparam int SETTLE = 4;
  localparam int TMO    = 2048;
`ifdef SEG_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  an_i;
  logic [7:0]  seg_i;
  logic [15:0] val_1_o;
  logic [15:0] val_2_o;
  logic [7:0]  dp_o;
  logic        valid_o;
  logic        err_o;
  logic        timeout_o;

  seg_scan_decoder #(.DIGITS(8), .SETTLE_CYCLES(SETTLE), .TIMEOUT(TMO)) dut (
    .clk_100MHz_i(clk),
    .rst(rst),
    .an_i(an_i),
    .seg_i(seg_i),
    .val_1_o(val_1_o),
    .val_2_o(val_2_o),
    .dp_o(dp_o),
    .valid_o(valid_o),
    .err_o(err_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] v1;
    logic [15:0] v2;
    logic [7:0]  dp;
    int          cyc;
  } frame_t;

  frame_t exp_q[$];
  frame_t obs_q[$];
  frame_t mon_f;
  int n_checks = 0;
  int n_errors = 0;
  logic [6:0] seg_tab [16];

  // Model state: hunting flag, digits seen, stored digits, expected flags.
  bit         m_hunt;
  logic [7:0] m_seen;
  logic [3:0] m_nib [8];
  logic [7:0] m_dp;
  bit         exp_err;
  bit         exp_tmo;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Record every published frame.
  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      mon_f.v1  = val_1_o;
      mon_f.v2  = val_2_o;
      mon_f.dp  = dp_o;
      mon_f.cyc = cyc;
      obs_q.push_back(mon_f);
      $display("frame cycle=%0d val_1=%h val_2=%h dp=%h err=%b", cyc, val_1_o, val_2_o, dp_o, err_o);
    end
  end

  task automatic model_reset();
    m_hunt  = 1'b1;
    m_seen  = '0;
    m_dp    = '0;
    exp_err = 1'b0;
    exp_tmo = 1'b0;
    for (int i = 0; i < 8; i++) m_nib[i] = 4'h0;
    exp_q.delete();
    obs_q.delete();
  endtask

  // A step held for at least SETTLE cycles counts as one observation of that anode.
  task automatic model_step(input logic [7:0] an, input logic [7:0] seg, input int hold, input int start);
    logic [7:0] act;
    logic [6:0] pat;
    int k;
    int nib;
    bit ok;
    frame_t f;
    if (hold < SETTLE || an == 8'hFF) return;
    act = ~an;
    if ($countones(act) != 1) begin
      exp_err = 1'b1;
      return;
    end
    k = 0;
    for (int b = 0; b < 8; b++) if (act[b]) k = b;
    pat = ~seg[6:0];
    ok  = 1'b0;
    nib = 0;
    for (int v = 0; v < 16; v++) if (seg_tab[v] == pat) begin nib = v; ok = 1'b1; end
    if (!ok) exp_err = 1'b1;
    if (m_hunt) begin
      if (k != 0) return;
      m_hunt = 1'b0;
      m_seen = '0;
    end
    m_nib[k] = 4'(nib);
    m_dp[k]  = ~seg[7];
    m_seen[k] = 1'b1;
    if (m_seen == 8'hFF) begin
      f.v1  = {m_nib[7], m_nib[6], m_nib[5], m_nib[4]};
      f.v2  = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
      f.dp  = m_dp;
      f.cyc = start + SETTLE + 2 + SYNC_LAT;
      exp_q.push_back(f);
      m_seen = '0;
    end
  endtask

  task automatic drive_step(input logic [7:0] an, input logic [7:0] seg, input int hold);
    an_i  = an;
    seg_i = seg;
    model_step(an, seg, hold, cyc);
    repeat (hold) @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive_step(8'hFF, 8'hFF, n);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    an_i  = 8'hFF;
    seg_i = 8'hFF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [7:0] rand_seg();
    int v;
    v = $urandom_range(15, 0);
    return {($urandom_range(1, 0) == 1), ~seg_tab[v]};
  endfunction

  // Scan digits first..last.
  // rnd adds random holds, blanks and short glitches; rep adds overwrite repeats.
  task automatic do_scan(input logic [15:0] v1, input logic [15:0] v2, input logic [7:0] dp,
                         input int first, input int last, input int hmin, input int hmax,
                         input bit rnd, input bit rep, input int bad_digit);
    for (int k = first; k <= last; k++) begin
      logic [3:0] nib;
      logic [7:0] seg;
      int j;
      nib = (k >= 4) ? v1[(k-4)*4 +: 4] : v2[k*4 +: 4];
      seg = {~dp[k], ~seg_tab[nib]};
      if (k == bad_digit) seg = {~dp[k], 7'h7F};
      if (rnd && $urandom_range(4, 0) == 0) begin
        j = (k + 3) % 8;
        drive_step(~(8'h01 << j), rand_seg(), $urandom_range(SETTLE - 1, 1));
        drive_step(8'hFF, 8'hFF, 1);
      end
      drive_step(~(8'h01 << k), seg, rnd ? $urandom_range(hmax, hmin) : hmax);
      if (rep && k > first && $urandom_range(5, 0) == 0) begin
        drive_step(8'hFF, 8'hFF, 1);
        drive_step(~(8'h01 << (k - 1)), rand_seg(), hmin);
      end
      if (rnd && $urandom_range(1, 0) == 1) drive_step(8'hFF, 8'hFF, $urandom_range(3, 1));
    end
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_frame_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({tag, "_val_1"}, 32'(obs_q[i].v1), 32'(exp_q[i].v1));
      chk({tag, "_val_2"}, 32'(obs_q[i].v2), 32'(exp_q[i].v2));
      chk({tag, "_dp"}, 32'(obs_q[i].dp), 32'(exp_q[i].dp));
      chk({tag, "_valid_cycle"}, 32'(obs_q[i].cyc), 32'(exp_q[i].cyc));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_err"}, 32'(err_o), 32'(exp_err));
    chk({tag, "_timeout"}, 32'(timeout_o), 32'(exp_tmo));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    rst   = 1'b1;
    an_i  = 8'hFF;
    seg_i = 8'hFF;
    @(negedge clk);
    do_reset();

    // Reset state.
    chk("rst_val_1", 32'(val_1_o), 32'(0));
    chk("rst_val_2", 32'(val_2_o), 32'(0));
    chk("rst_dp", 32'(dp_o), 32'(0));
    chk("rst_valid", 32'(valid_o), 32'(0));
    chk("rst_err", 32'(err_o), 32'(0));
    chk("rst_timeout", 32'(timeout_o), 32'(0));

    // Clean scan, 16 cycles per digit.
    do_scan(16'h1A2F, 16'hC039, 8'h00, 0, 7, 16, 16, 1'b0, 1'b0, -1);
    idle(20);
    check_frames("scan_1a2f");
    chk("hold_val_1", 32'(val_1_o), 32'(16'h1A2F));
    chk("hold_val_2", 32'(val_2_o), 32'(16'hC039));
    check_flags("scan_1a2f");

    // Random clean scans with blanks, glitches and overwrite repeats.
    for (int s = 0; s < 24; s++) begin
      do_scan(16'($urandom), 16'($urandom), 8'($urandom), 0, 7, SETTLE, 12, 1'b1, 1'b1, -1);
    end
    idle(20);
    check_frames("random");
    check_flags("random");

    // Multi-hot anode in the middle of a scan, followed by a clean scan.
    do_scan(16'($urandom), 16'($urandom), 8'($urandom), 0, 3, SETTLE, 12, 1'b1, 1'b0, -1);
    drive_step(8'hF3, rand_seg(), 16);
    do_scan(16'($urandom), 16'($urandom), 8'($urandom), 4, 7, SETTLE, 12, 1'b1, 1'b0, -1);
    do_scan(16'h5E71, 16'h0B3D, 8'hA5, 0, 7, SETTLE, 12, 1'b1, 1'b0, -1);
    idle(20);
    check_frames("multihot");
    check_flags("multihot");

    // Reset after 5 digits, then a blanked scan of FFFF/0000.
    do_scan(16'($urandom), 16'($urandom), 8'($urandom), 0, 4, 16, 16, 1'b0, 1'b0, -1);
    do_reset();
    chk("midrst_err", 32'(err_o), 32'(0));
    chk("midrst_val_1", 32'(val_1_o), 32'(0));
    for (int k = 0; k < 8; k++) begin
      drive_step(~(8'h01 << k), {1'b1, ~seg_tab[(k >= 4) ? 15 : 0]}, 16);
      drive_step(8'hFF, 8'hFF, 3);
    end
    idle(20);
    chk("midrst_new_val_1", 32'(val_1_o), 32'(16'hFFFF));
    chk("midrst_new_val_2", 32'(val_2_o), 32'(16'h0000));
    check_frames("midrst");
    check_flags("midrst");

    // Illegal segment pattern on digit 2.
    do_scan(16'($urandom), 16'hFFFF, 8'($urandom), 0, 7, 16, 16, 1'b0, 1'b0, 2);
    idle(20);
    chk("badseg_nib2", 32'(val_2_o[11:8]), 32'(0));
    check_frames("badseg");
    check_flags("badseg");

    // Timeout: digit 0 opens a frame, digit 1 is too short, then the bus idles.
    do_reset();
    drive_step(8'hFE, {1'b1, ~seg_tab[3]}, 16);
    drive_step(8'hFD, {1'b1, ~seg_tab[4]}, SETTLE - 1);
    idle(TMO / 2);
    chk("tmo_early", 32'(timeout_o), 32'(0));
    idle(TMO);
    m_hunt  = 1'b1;
    m_seen  = '0;
    exp_tmo = 1'b1;
    check_flags("tmo");
    // Back in HUNT: a partial 3..7 run must not combine with the next scan.
    do_scan(16'($urandom), 16'($urandom), 8'($urandom), 3, 7, SETTLE, 12, 1'b1, 1'b0, -1);
    do_scan(16'h2468, 16'h9ACE, 8'h3C, 0, 7, SETTLE, 12, 1'b1, 1'b0, -1);
    idle(20);
    check_frames("after_tmo");
    check_flags("after_tmo");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
